// File: rtl/ppu_pkg.sv
// ppu_pkg
//   Shared definitions for the PPU scanline path: row geometry, the
//   row-RAM entry layout and the row-buffer sequencing states.
package ppu_pkg;

  localparam int ROW_PIXELS = 320;  // entries per scanline bank
  localparam int ROWS       = 240;  // game rows per frame

  // One row-RAM entry: 9-bit palette address plus a select bit.
  typedef struct packed {
    logic [8:0] palette_addr;
    logic       sel;
  } rowram_entry_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,  // no row in progress, swaps ignored
    RENDER = 2'd1,  // render requested, not yet complete
    READY  = 2'd2   // write bank holds a complete row
  } rowbuf_state_t;

endpackage

// File: rtl/row_bank_ram.sv
// row_bank_ram
//   Two banks of DEPTH x DATA_W simple dual-port RAM. The bank bit acts as
//   the address MSB on both ports. Write port and read port are independent;
//   the read port has one cycle of latency. Contents are not reset.
//
// Ports:
//   video_clk  clock
//   we         write enable
//   wbank      write bank select
//   waddr      write address within the bank (caller guarantees < DEPTH)
//   wdata      write data
//   rbank      read bank select
//   raddr      read address within the bank (caller guarantees < DEPTH)
//   rdata_p1   registered read data
module row_bank_ram #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 320,
  parameter int ADDR_W = 9
) (
  input  logic              video_clk,
  input  logic              we,
  input  logic              wbank,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rbank,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata_p1
);

  logic [DATA_W-1:0] mem [2][DEPTH];

  always_ff @(posedge video_clk) begin
    if (we) begin
      mem[wbank][waddr] <= wdata;
    end
  end

  // p0 -> p1: registered read
  always_ff @(posedge video_clk) begin
    rdata_p1 <= mem[rbank][raddr];
  end

endmodule

// File: rtl/ppu_row_buffer.sv
// ppu_row_buffer
//   Double-buffered scanline store between the PPU row renderer and the
//   HDMI output stage. The renderer fills the write bank (~rd_bank) while
//   the video side reads the display bank (rd_bank). Each game row is shown
//   on two consecutive output lines: the first swap of a row toggles the
//   banks and requests the next row, the second swap repeats the row.
//
// Ports:
//   video_clk       pixel clock
//   rst_n           asynchronous active-low reset
//   rowram_rdaddr   video read address
//   rowram_rddata   display-bank entry, one cycle after the address
//   rowram_swap     once-per-line swap strobe, before the read burst
//   vblank_start    start of vertical blank strobe
//   vblank_end      one line before the first visible line strobe
//   render_start    one-cycle render request for render_row
//   render_row      game row index to render
//   wr_en/wr_addr/wr_data  renderer write port
//   render_done     requested row fully written
//   underrun        one-cycle pulse: row not ready at its toggle swap
//   underrun_count  saturating underrun count since reset
//   wr_oob          sticky: a write addressed beyond the row
module ppu_row_buffer #(
  parameter int ROW_PIXELS  = ppu_pkg::ROW_PIXELS,
  parameter int ROWS        = ppu_pkg::ROWS,
  parameter int LINE_REPEAT = 2,
  parameter int DATA_W      = 10
) (
  input  logic              video_clk,
  input  logic              rst_n,
  input  logic [8:0]        rowram_rdaddr,
  output logic [DATA_W-1:0] rowram_rddata,
  input  logic              rowram_swap,
  input  logic              vblank_start,
  input  logic              vblank_end,
  output logic              render_start,
  output logic [7:0]        render_row,
  input  logic              wr_en,
  input  logic [8:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              render_done,
  output logic              underrun,
  output logic [15:0]       underrun_count,
  output logic              wr_oob
);

  import ppu_pkg::*;

  // The swap sequencing below assumes a two-line repeat: odd swap_idx is
  // the toggle swap, even non-zero swap_idx is the repeat swap.
  if (LINE_REPEAT != 2) begin : g_bad_line_repeat
    $error("ppu_row_buffer supports LINE_REPEAT == 2 only");
  end

  localparam logic [8:0] PIX_LIM  = 9'(ROW_PIXELS);
  localparam logic [7:0] LAST_ROW = 8'(ROWS - 1);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  rowbuf_state_t state;
  logic          rd_bank;
  logic [8:0]    swap_idx;

  // Write guard: out-of-row writes never reach the RAM.
  logic wr_ok;
  assign wr_ok = wr_en && (wr_addr < PIX_LIM);

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_oob <= 1'b0;
    end else if (wr_en && !wr_ok) begin
      wr_oob <= 1'b1;
    end
  end

  // Read guard: out-of-row reads use a safe RAM address and are masked
  // to zero at the output by the travelling valid bit.
  logic              rd_in_range_p0;
  logic [8:0]        rd_addr_p0;
  logic [DATA_W-1:0] rd_word_p1;
  logic              vld_p1;

  assign rd_in_range_p0 = rowram_rdaddr < PIX_LIM;
  assign rd_addr_p0     = rd_in_range_p0 ? rowram_rdaddr : 9'd0;

  row_bank_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (ROW_PIXELS),
    .ADDR_W (9)
  ) u_ram (
    .video_clk (video_clk),
    .we        (wr_ok),
    .wbank     (~rd_bank),
    .waddr     (wr_addr),
    .wdata     (wr_data),
    .rbank     (rd_bank),
    .raddr     (rd_addr_p0),
    .rdata_p1  (rd_word_p1)
  );

  // p0 -> p1: valid alongside the RAM read register
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= rd_in_range_p0;
    end
  end

  assign rowram_rddata = vld_p1 ? rd_word_p1 : '0;

  // Row sequencing. A read presented on a swap edge sees the pre-swap bank
  // because the RAM samples rd_bank before this block updates it.
  logic toggle_swap;
  logic row_ready;

  assign toggle_swap = swap_idx[0];
  // A render_done landing on the toggle edge counts as a finished row.
  assign row_ready   = (state == READY) || ((state == RENDER) && render_done);

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      rd_bank        <= 1'b0;
      swap_idx       <= 9'd0;
      render_start   <= 1'b0;
      render_row     <= 8'd0;
      underrun       <= 1'b0;
      underrun_count <= 16'd0;
    end else begin
      render_start <= 1'b0;
      underrun     <= 1'b0;

      if (vblank_start) begin
        // Blanking abandons any row in progress; the displayed bank stays.
        state <= IDLE;
      end else if (vblank_end) begin
        swap_idx     <= 9'd0;
        render_row   <= 8'd0;
        render_start <= 1'b1;
        state        <= RENDER;
      end else if (rowram_swap && (state != IDLE)) begin
        swap_idx <= swap_idx + 9'd1;
        if (toggle_swap) begin
          // The toggle happens even when late so a partial row is shown.
          rd_bank <= ~rd_bank;
          if (!row_ready) begin
            underrun       <= 1'b1;
            underrun_count <= sat_inc16(underrun_count);
          end
          if (render_row < LAST_ROW) begin
            render_row   <= render_row + 8'd1;
            render_start <= 1'b1;
            state        <= RENDER;
          end else begin
            state <= IDLE;
          end
        end else if (render_done && (state == RENDER)) begin
          // Priming or repeat swap: banks untouched, completion still noted.
          state <= READY;
        end
      end else if (render_done && (state == RENDER)) begin
        state <= READY;
      end
    end
  end

endmodule

// File: tb/tb_ppu_row_buffer.sv
// tb_ppu_row_buffer
//   Directed bench for ppu_row_buffer: priming, line repeat, underrun,
//   out-of-row writes, frame end and mid-frame reset.
module tb_ppu_row_buffer;
  import ppu_pkg::*;

  logic        video_clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [8:0]  rowram_rdaddr = '0;
  logic [9:0]  rowram_rddata;
  logic        rowram_swap = 1'b0;
  logic        vblank_start = 1'b0;
  logic        vblank_end = 1'b0;
  logic        render_start;
  logic [7:0]  render_row;
  logic        wr_en = 1'b0;
  logic [8:0]  wr_addr = '0;
  logic [9:0]  wr_data = '0;
  logic        render_done = 1'b0;
  logic        underrun;
  logic [15:0] underrun_count;
  logic        wr_oob;

  int total = 0;
  int bad = 0;

  always #5 video_clk = ~video_clk;

  ppu_row_buffer dut (
    .video_clk      (video_clk),
    .rst_n          (rst_n),
    .rowram_rdaddr  (rowram_rdaddr),
    .rowram_rddata  (rowram_rddata),
    .rowram_swap    (rowram_swap),
    .vblank_start   (vblank_start),
    .vblank_end     (vblank_end),
    .render_start   (render_start),
    .render_row     (render_row),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .render_done    (render_done),
    .underrun       (underrun),
    .underrun_count (underrun_count),
    .wr_oob         (wr_oob)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs set afterwards are sampled at the next edge.
  task automatic step();
    @(posedge video_clk);
    #1;
  endtask

  task automatic pulse_swap();
    rowram_swap = 1'b1;
    step();
    rowram_swap = 1'b0;
  endtask

  task automatic pulse_done();
    render_done = 1'b1;
    step();
    render_done = 1'b0;
  endtask

  task automatic read_at(input logic [8:0] a);
    rowram_rdaddr = a;
    step();
  endtask

  task automatic write_row(input logic use_addr, input logic [9:0] val);
    for (int i = 0; i < 320; i++) begin
      wr_en   = 1'b1;
      wr_addr = 9'(i);
      wr_data = use_addr ? 10'(i) : val;
      step();
    end
    wr_en = 1'b0;
  endtask

  initial begin
    logic saw_start;

    // Reset
    #1 rst_n = 1'b0;
    step();
    step();
    chk("rst_render_start", 32'(render_start), 32'd0);
    chk("rst_render_row", 32'(render_row), 32'd0);
    chk("rst_rddata", 32'(rowram_rddata), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_underrun_count", 32'(underrun_count), 32'd0);
    chk("rst_wr_oob", 32'(wr_oob), 32'd0);
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    rst_n = 1'b1;
    step();

    // Swap while idle is ignored
    pulse_swap();
    chk("idle_swap_bank", 32'(dut.rd_bank), 32'd0);
    chk("idle_swap_start", 32'(render_start), 32'd0);

    // Frame start: row 0 requested one cycle after vblank_end
    vblank_end = 1'b1;
    step();
    vblank_end = 1'b0;
    chk("vbe_render_start", 32'(render_start), 32'd1);
    chk("vbe_render_row", 32'(render_row), 32'd0);
    step();
    chk("vbe_start_one_cycle", 32'(render_start), 32'd0);

    // Row 0 written with data = addr, done ~900 cycles after request
    write_row(1'b1, 10'd0);
    repeat (578) step();
    pulse_done();

    // Priming swap: no bank change
    pulse_swap();
    chk("prime_bank", 32'(dut.rd_bank), 32'd0);
    chk("prime_start", 32'(render_start), 32'd0);

    // Toggle swap for row 0
    pulse_swap();
    chk("row0_toggle_bank", 32'(dut.rd_bank), 32'd1);
    chk("row0_toggle_start", 32'(render_start), 32'd1);
    chk("row0_toggle_row", 32'(render_row), 32'd1);
    chk("row0_toggle_underrun", 32'(underrun), 32'd0);
    read_at(9'd5);
    chk("row0_rd5", 32'(rowram_rddata), 32'd5);
    read_at(9'd319);
    chk("row0_rd319", 32'(rowram_rddata), 32'd319);

    // Row 1 = 0x3FF, then repeat swap keeps row 0 on screen
    write_row(1'b0, 10'h3FF);
    pulse_done();
    pulse_swap();
    chk("repeat_bank", 32'(dut.rd_bank), 32'd1);
    chk("repeat_start", 32'(render_start), 32'd0);
    read_at(9'd5);
    chk("repeat_rd5", 32'(rowram_rddata), 32'd5);

    // Toggle for row 1 with a read on the swap edge: old bank, then new
    rowram_rdaddr = 9'd5;
    rowram_swap   = 1'b1;
    step();
    rowram_swap   = 1'b0;
    chk("swap_edge_read_old_bank", 32'(rowram_rddata), 32'd5);
    chk("row1_toggle_row", 32'(render_row), 32'd2);
    chk("row1_toggle_start", 32'(render_start), 32'd1);
    step();
    chk("row1_rd5", 32'(rowram_rddata), 32'h3FF);

    // Underrun: row 2 never completes before its toggle swap
    pulse_swap();
    pulse_swap();
    chk("underrun_pulse", 32'(underrun), 32'd1);
    chk("underrun_count1", 32'(underrun_count), 32'd1);
    chk("underrun_bank", 32'(dut.rd_bank), 32'd1);
    chk("underrun_start", 32'(render_start), 32'd1);
    chk("underrun_row", 32'(render_row), 32'd3);
    step();
    chk("underrun_one_cycle", 32'(underrun), 32'd0);
    read_at(9'd5);
    chk("underrun_partial_rd5", 32'(rowram_rddata), 32'd5);

    // Out-of-row write and read
    wr_en   = 1'b1;
    wr_addr = 9'd320;
    wr_data = 10'h155;
    step();
    wr_en = 1'b0;
    chk("oob_flag", 32'(wr_oob), 32'd1);
    read_at(9'd320);
    chk("oob_rd320", 32'(rowram_rddata), 32'd0);
    read_at(9'd64);
    chk("oob_bank_intact", 32'(rowram_rddata), 32'd64);
    step();
    chk("oob_sticky", 32'(wr_oob), 32'd1);

    // render_done coincident with the toggle swap counts as ready
    pulse_swap();
    rowram_swap = 1'b1;
    render_done = 1'b1;
    step();
    rowram_swap = 1'b0;
    render_done = 1'b0;
    chk("coinc_underrun", 32'(underrun), 32'd0);
    chk("coinc_count", 32'(underrun_count), 32'd1);
    chk("coinc_bank", 32'(dut.rd_bank), 32'd0);
    chk("coinc_row", 32'(render_row), 32'd4);

    // Remaining rows 4..239
    for (int r = 4; r < 240; r++) begin
      pulse_done();
      pulse_swap();
      pulse_swap();
    end
    chk("frame_end_state", 32'(dut.state), 32'(IDLE));
    chk("frame_end_row", 32'(render_row), 32'd239);
    chk("frame_end_start", 32'(render_start), 32'd0);
    chk("frame_end_bank", 32'(dut.rd_bank), 32'd0);
    chk("frame_end_count", 32'(underrun_count), 32'd1);
    pulse_swap();
    chk("post_frame_swap1_start", 32'(render_start), 32'd0);
    pulse_swap();
    chk("post_frame_swap2_start", 32'(render_start), 32'd0);
    chk("post_frame_bank", 32'(dut.rd_bank), 32'd0);
    vblank_start = 1'b1;
    step();
    vblank_start = 1'b0;
    chk("vbs_state", 32'(dut.state), 32'(IDLE));
    chk("vbs_bank", 32'(dut.rd_bank), 32'd0);
    chk("vbs_underrun", 32'(underrun), 32'd0);

    // Second frame up to row 100, then reset mid-frame
    vblank_end = 1'b1;
    step();
    vblank_end = 1'b0;
    for (int r = 0; r < 100; r++) begin
      pulse_done();
      pulse_swap();
      pulse_swap();
    end
    chk("pre_reset_row", 32'(render_row), 32'd100);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_render_row", 32'(render_row), 32'd0);
    chk("midrst_render_start", 32'(render_start), 32'd0);
    chk("midrst_count", 32'(underrun_count), 32'd0);
    chk("midrst_wr_oob", 32'(wr_oob), 32'd0);
    chk("midrst_rddata", 32'(rowram_rddata), 32'd0);
    chk("midrst_bank", 32'(dut.rd_bank), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // No render requests until the next vblank_end
    saw_start = 1'b0;
    render_done = 1'b1;
    step();
    render_done = 1'b0;
    saw_start |= render_start;
    for (int k = 0; k < 4; k++) begin
      pulse_swap();
      saw_start |= render_start;
      step();
      saw_start |= render_start;
    end
    chk("post_rst_no_start", 32'(saw_start), 32'd0);
    chk("post_rst_bank", 32'(dut.rd_bank), 32'd0);
    vblank_end = 1'b1;
    step();
    vblank_end = 1'b0;
    chk("resume_start", 32'(render_start), 32'd1);
    chk("resume_row", 32'(render_row), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
